// File: rtl/tx_mac_lite_pad_stat.sv
// tx_mac_lite_pad_stat: TX frame conditioner of the lite Ethernet MAC.
// Gates whole frames by an MI-controlled enable, zero-pads short single-word
// frames to MIN_FRAME_LEN and keeps wrapping transmit statistics with MI32
// snapshot/clear commands.
// Optional feature macro: TX_MAC_LITE_PAD_EN (defined = padding and the
// PADDED counter are present; undefined = short frames pass unchanged).
module tx_mac_lite_pad_stat #(
  parameter int MIN_FRAME_LEN = 60,
  parameter int CNT_WIDTH     = 64
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [511:0] RX_MFB_DATA,
  input  logic         RX_MFB_SOF,
  input  logic         RX_MFB_EOF,
  input  logic [5:0]   RX_MFB_EOF_POS,
  input  logic         RX_MFB_SRC_RDY,
  output logic         RX_MFB_DST_RDY,
  output logic [511:0] TX_MFB_DATA,
  output logic         TX_MFB_SOF,
  output logic         TX_MFB_EOF,
  output logic [5:0]   TX_MFB_EOF_POS,
  output logic         TX_MFB_SRC_RDY,
  input  logic         TX_MFB_DST_RDY,
  input  logic [31:0]  MI_DWR,
  input  logic [31:0]  MI_ADDR,
  input  logic [3:0]   MI_BE,
  input  logic         MI_RD,
  input  logic         MI_WR,
  output logic         MI_ARDY,
  output logic [31:0]  MI_DRD,
  output logic         MI_DRDY
);

  typedef enum logic [1:0] {IDLE, FORWARD, DISCARD} state_t;

  // Counter slots: 0 FRAMES, 1 OCTETS, 2 PADDED, 3 DISCARD
  localparam int NUM_CNT = 4;

  state_t state_reg, state_next;

  logic         rx_xfer;
  logic         fwd_word;
  logic         discard_eof;
  logic [15:0]  byte_cnt_reg;
  logic [15:0]  len_base;
  logic [6:0]   eof_len;
  logic [16:0]  len_sum;
  logic [15:0]  len_sat;
  logic         pad_req;
  logic [511:0] pad_data;
  logic [5:0]   pad_eof_pos;
  logic [15:0]  pad_len;

  logic [511:0] tx_data_reg;
  logic         tx_sof_reg;
  logic         tx_eof_reg;
  logic [5:0]   tx_eof_pos_reg;
  logic         tx_src_rdy_reg;
  logic [15:0]  tx_len_reg;
  logic         tx_padded_reg;
  logic         tx_eof_xfer;

  logic                 enable_reg;
  logic [CNT_WIDTH-1:0] cnt_reg  [NUM_CNT];
  logic [CNT_WIDTH-1:0] snap_reg [NUM_CNT];
  logic [CNT_WIDTH-1:0] inc_val  [NUM_CNT];

  logic [3:0]  mi_addr;
  logic        mi_wr_ok;
  logic        cmd_snap;
  logic        cmd_clr;
  logic [63:0] rd_ext;
  logic [31:0] rd_data;
  logic [31:0] drd_reg;
  logic        drdy_reg;
  logic        unused_bits;

  // Output register can take a new word when empty or when it drains this cycle
  assign RX_MFB_DST_RDY = TX_MFB_DST_RDY || !tx_src_rdy_reg;
  assign rx_xfer        = RX_MFB_SRC_RDY && RX_MFB_DST_RDY;
  assign tx_eof_xfer    = tx_src_rdy_reg && TX_MFB_DST_RDY && tx_eof_reg;

  assign TX_MFB_DATA    = tx_data_reg;
  assign TX_MFB_SOF     = tx_sof_reg;
  assign TX_MFB_EOF     = tx_eof_reg;
  assign TX_MFB_EOF_POS = tx_eof_pos_reg;
  assign TX_MFB_SRC_RDY = tx_src_rdy_reg;

  assign MI_ARDY  = 1'b1;
  assign MI_DRD   = drd_reg;
  assign MI_DRDY  = drdy_reg;
  assign mi_addr  = MI_ADDR[5:2];
  assign mi_wr_ok = MI_WR && MI_BE[0];
  assign cmd_snap = mi_wr_ok && (mi_addr == 4'd9) && MI_DWR[0];
  assign cmd_clr  = mi_wr_ok && (mi_addr == 4'd9) && MI_DWR[1];

  assign unused_bits = ^{MI_ADDR[31:6], MI_ADDR[1:0], MI_BE[3:1], MI_DWR[31:2]};

  // Frame state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Frame decisions: a SOF always restarts the decision, whatever the state
  always_comb begin
    state_next  = state_reg;
    fwd_word    = 1'b0;
    discard_eof = 1'b0;
    if (rx_xfer) begin
      if (RX_MFB_SOF) begin
        if (enable_reg) begin
          fwd_word   = 1'b1;
          state_next = RX_MFB_EOF ? IDLE : FORWARD;
        end else begin
          discard_eof = RX_MFB_EOF;
          state_next  = RX_MFB_EOF ? IDLE : DISCARD;
        end
      end else begin
        case (state_reg)
          FORWARD: begin
            fwd_word = 1'b1;
            if (RX_MFB_EOF) state_next = IDLE;
          end
          DISCARD: begin
            discard_eof = RX_MFB_EOF;
            if (RX_MFB_EOF) state_next = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating frame length: prior words of this frame plus this word's bytes
  assign len_base = RX_MFB_SOF ? 16'd0 : byte_cnt_reg;
  assign eof_len  = {1'b0, RX_MFB_EOF_POS} + 7'd1;
  assign len_sum  = {1'b0, len_base} + (RX_MFB_EOF ? {10'd0, eof_len} : 17'd64);
  assign len_sat  = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  // Byte counter tracks the running length of the current frame
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)        byte_cnt_reg <= 16'd0;
    else if (rx_xfer) byte_cnt_reg <= len_sat;
  end

`ifdef TX_MAC_LITE_PAD_EN
  // Only single-word frames can be short, since MIN_FRAME_LEN fits in one word
  assign pad_req = RX_MFB_SOF && RX_MFB_EOF && (eof_len < 7'(MIN_FRAME_LEN));
`else
  assign pad_req = 1'b0;
`endif

  assign pad_eof_pos = pad_req ? 6'(MIN_FRAME_LEN - 1) : RX_MFB_EOF_POS;
  assign pad_len     = pad_req ? 16'(MIN_FRAME_LEN) : len_sat;

  // Bytes between the original end and MIN_FRAME_LEN-1 become zero when padding
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_pad_byte
      if (gi < MIN_FRAME_LEN) begin : g_maskable
        assign pad_data[gi*8 +: 8] =
          (pad_req && (7'(gi) > {1'b0, RX_MFB_EOF_POS})) ? 8'h00 : RX_MFB_DATA[gi*8 +: 8];
      end else begin : g_pass
        assign pad_data[gi*8 +: 8] = RX_MFB_DATA[gi*8 +: 8];
      end
    end
  endgenerate

  // Single output register stage; holds while downstream stalls
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tx_data_reg    <= '0;
      tx_sof_reg     <= 1'b0;
      tx_eof_reg     <= 1'b0;
      tx_eof_pos_reg <= 6'd0;
      tx_src_rdy_reg <= 1'b0;
      tx_len_reg     <= 16'd0;
      tx_padded_reg  <= 1'b0;
    end else if (fwd_word) begin
      tx_data_reg    <= pad_data;
      tx_sof_reg     <= RX_MFB_SOF;
      tx_eof_reg     <= RX_MFB_EOF;
      tx_eof_pos_reg <= pad_eof_pos;
      tx_src_rdy_reg <= 1'b1;
      tx_len_reg     <= pad_len;
      tx_padded_reg  <= pad_req;
    end else if (TX_MFB_DST_RDY) begin
      tx_src_rdy_reg <= 1'b0;
    end
  end

  // Per-counter increment for this cycle
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) inc_val[i] = '0;
    if (tx_eof_xfer) begin
      inc_val[0] = CNT_WIDTH'(1);
      inc_val[1] = CNT_WIDTH'(tx_len_reg);
      inc_val[2] = CNT_WIDTH'(tx_padded_reg);
    end
    if (discard_eof) inc_val[3] = CNT_WIDTH'(1);
  end

  // Live counters and snapshots; clear beats increment, snapshot sees old value
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_reg[i]  <= '0;
        snap_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (cmd_clr) cnt_reg[i] <= '0;
        else         cnt_reg[i] <= cnt_reg[i] + inc_val[i];
        if (cmd_snap) snap_reg[i] <= cnt_reg[i];
      end
    end
  end

  // CTRL enable register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                               enable_reg <= 1'b0;
    else if (mi_wr_ok && (mi_addr == 4'd8))  enable_reg <= MI_DWR[0];
  end

  // MI read decode
  always_comb begin
    rd_data = '0;
    rd_ext  = 64'(snap_reg[mi_addr[2:1]]);
    if (!mi_addr[3]) begin
      rd_data = mi_addr[0] ? rd_ext[63:32] : rd_ext[31:0];
`ifndef TX_MAC_LITE_PAD_EN
      if (mi_addr[2:1] == 2'd2) rd_data = '0;
`endif
    end else if (mi_addr == 4'd8) begin
      rd_data = {31'd0, enable_reg};
    end
  end

  // MI read response one cycle after the strobe
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      drdy_reg <= 1'b0;
      drd_reg  <= '0;
    end else begin
      drdy_reg <= MI_RD;
      drd_reg  <= MI_RD ? rd_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_tx_mac_lite_pad_stat.sv
// Directed self-checking bench for tx_mac_lite_pad_stat.
module tb_tx_mac_lite_pad_stat;

`ifdef TX_MAC_LITE_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RESET;
  logic [511:0] RX_MFB_DATA;
  logic         RX_MFB_SOF, RX_MFB_EOF;
  logic [5:0]   RX_MFB_EOF_POS;
  logic         RX_MFB_SRC_RDY;
  logic         RX_MFB_DST_RDY;
  logic [511:0] TX_MFB_DATA;
  logic         TX_MFB_SOF, TX_MFB_EOF;
  logic [5:0]   TX_MFB_EOF_POS;
  logic         TX_MFB_SRC_RDY;
  logic         TX_MFB_DST_RDY;
  logic [31:0]  MI_DWR, MI_ADDR;
  logic [3:0]   MI_BE;
  logic         MI_RD, MI_WR;
  logic         MI_ARDY;
  logic [31:0]  MI_DRD;
  logic         MI_DRDY;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  tx_mac_lite_pad_stat #(.MIN_FRAME_LEN(60), .CNT_WIDTH(64)) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_MFB_DATA(RX_MFB_DATA), .RX_MFB_SOF(RX_MFB_SOF), .RX_MFB_EOF(RX_MFB_EOF),
    .RX_MFB_EOF_POS(RX_MFB_EOF_POS), .RX_MFB_SRC_RDY(RX_MFB_SRC_RDY),
    .RX_MFB_DST_RDY(RX_MFB_DST_RDY),
    .TX_MFB_DATA(TX_MFB_DATA), .TX_MFB_SOF(TX_MFB_SOF), .TX_MFB_EOF(TX_MFB_EOF),
    .TX_MFB_EOF_POS(TX_MFB_EOF_POS), .TX_MFB_SRC_RDY(TX_MFB_SRC_RDY),
    .TX_MFB_DST_RDY(TX_MFB_DST_RDY),
    .MI_DWR(MI_DWR), .MI_ADDR(MI_ADDR), .MI_BE(MI_BE), .MI_RD(MI_RD), .MI_WR(MI_WR),
    .MI_ARDY(MI_ARDY), .MI_DRD(MI_DRD), .MI_DRDY(MI_DRDY)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word whose byte i is base+i
  function automatic logic [511:0] mk_word(input logic [7:0] base);
    logic [511:0] w;
    for (int i = 0; i < 64; i++) w[i*8 +: 8] = base + 8'(i);
    return w;
  endfunction

  // Expected output data for a single-word frame ending at byte 'last'
  function automatic logic [511:0] exp_data(input logic [511:0] d, input int last);
    logic [511:0] r;
    r = d;
    if (PAD && (last + 1 < 60))
      for (int i = last + 1; i < 60; i++) r[i*8 +: 8] = 8'h00;
    return r;
  endfunction

  task automatic send(input logic sof, input logic eof, input logic [5:0] pos,
                      input logic [511:0] data);
    int n;
    RX_MFB_DATA    = data;
    RX_MFB_SOF     = sof;
    RX_MFB_EOF     = eof;
    RX_MFB_EOF_POS = pos;
    RX_MFB_SRC_RDY = 1'b1;
    n = 0;
    while (!RX_MFB_DST_RDY && n < 50) begin
      tick;
      n++;
    end
    chk("rx_accept", RX_MFB_DST_RDY, 1'b1);
    tick;
    RX_MFB_SRC_RDY = 1'b0;
    RX_MFB_SOF     = 1'b0;
    RX_MFB_EOF     = 1'b0;
  endtask

  task automatic mi_write(input logic [31:0] addr, input logic [31:0] data);
    MI_ADDR = addr;
    MI_DWR  = data;
    MI_BE   = 4'hF;
    MI_WR   = 1'b1;
    tick;
    MI_WR   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    MI_ADDR = addr;
    MI_RD   = 1'b1;
    tick;
    MI_RD   = 1'b0;
    chk({tag, "_drdy"}, MI_DRDY, 1'b1);
    chk(tag, MI_DRD, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] w;
    logic [511:0] held;

    RESET = 1'b1;
    RX_MFB_DATA = '0; RX_MFB_SOF = 0; RX_MFB_EOF = 0; RX_MFB_EOF_POS = 0;
    RX_MFB_SRC_RDY = 0; TX_MFB_DST_RDY = 1;
    MI_DWR = 0; MI_ADDR = 0; MI_BE = 0; MI_RD = 0; MI_WR = 0;
    repeat (3) tick;

    // Reset state
    chk("rst_tx_src_rdy", TX_MFB_SRC_RDY, 1'b0);
    chk("rst_tx_data", TX_MFB_DATA, '0);
    chk("rst_tx_eof_pos", TX_MFB_EOF_POS, 6'd0);
    chk("rst_mi_drdy", MI_DRDY, 1'b0);
    chk("rst_mi_drd", MI_DRD, 32'd0);
    chk("rst_rx_dst_rdy", RX_MFB_DST_RDY, 1'b1);
    chk("mi_ardy", MI_ARDY, 1'b1);
    RESET = 1'b0;
    tick;
    rd_chk("rst_ctrl", 32'h20, 32'd0);
    rd_chk("rst_frames", 32'h00, 32'd0);

    // 42-byte frame, forwarded and padded
    mi_write(32'h20, 32'd1);
    rd_chk("ctrl_en", 32'h20, 32'd1);
    w = mk_word(8'h80);
    send(1, 1, 6'd41, w);
    chk("pad42_src_rdy", TX_MFB_SRC_RDY, 1'b1);
    chk("pad42_sof_eof", {TX_MFB_SOF, TX_MFB_EOF}, 2'b11);
    chk("pad42_eof_pos", TX_MFB_EOF_POS, PAD ? 6'd59 : 6'd41);
    chk("pad42_data", TX_MFB_DATA, exp_data(w, 41));
    tick;
    chk("pad42_drained", TX_MFB_SRC_RDY, 1'b0);
    mi_write(32'h24, 32'd1);
    rd_chk("pad42_frames", 32'h00, 32'd1);
    rd_chk("pad42_frames_hi", 32'h04, 32'd0);
    rd_chk("pad42_octets", 32'h08, PAD ? 32'd60 : 32'd42);
    rd_chk("pad42_padded", 32'h10, PAD ? 32'd1 : 32'd0);
    rd_chk("cmd_reads_zero", 32'h24, 32'd0);
    rd_chk("unmapped_zero", 32'h3C, 32'd0);

    // Boundary: 60 bytes (no pad) and 59 bytes (one byte of pad)
    w = mk_word(8'h81);
    send(1, 1, 6'd59, w);
    chk("len60_eof_pos", TX_MFB_EOF_POS, 6'd59);
    chk("len60_data", TX_MFB_DATA, w);
    w = mk_word(8'h82);
    send(1, 1, 6'd58, w);
    chk("len59_eof_pos", TX_MFB_EOF_POS, PAD ? 6'd59 : 6'd58);
    chk("len59_data", TX_MFB_DATA, exp_data(w, 58));
    tick;
    mi_write(32'h24, 32'd1);
    rd_chk("bnd_frames", 32'h00, 32'd3);
    rd_chk("bnd_octets", 32'h08, PAD ? 32'd180 : 32'd161);
    rd_chk("bnd_padded", 32'h10, PAD ? 32'd2 : 32'd0);

    // Disabled: 3-word frame discarded
    mi_write(32'h24, 32'd2);
    mi_write(32'h20, 32'd0);
    send(1, 0, 6'd0, mk_word(8'h01));
    chk("disc_w0", TX_MFB_SRC_RDY, 1'b0);
    send(0, 0, 6'd0, mk_word(8'h02));
    chk("disc_w1", TX_MFB_SRC_RDY, 1'b0);
    send(0, 1, 6'd10, mk_word(8'h03));
    chk("disc_w2", TX_MFB_SRC_RDY, 1'b0);
    tick;
    mi_write(32'h24, 32'd1);
    rd_chk("disc_discard", 32'h18, 32'd1);
    rd_chk("disc_frames", 32'h00, 32'd0);

    // 200-byte frame with enable dropped after word 0: whole frame forwarded
    mi_write(32'h24, 32'd2);
    mi_write(32'h20, 32'd1);
    send(1, 0, 6'd0, mk_word(8'h10));
    chk("f200_w0_sof", {TX_MFB_SRC_RDY, TX_MFB_SOF}, 2'b11);
    chk("f200_w0_data", TX_MFB_DATA, mk_word(8'h10));
    mi_write(32'h20, 32'd0);
    send(0, 0, 6'd0, mk_word(8'h11));
    chk("f200_w1", {TX_MFB_SRC_RDY, TX_MFB_EOF}, 2'b10);
    chk("f200_w1_data", TX_MFB_DATA, mk_word(8'h11));
    send(0, 0, 6'd0, mk_word(8'h12));
    chk("f200_w2_data", TX_MFB_DATA, mk_word(8'h12));
    send(0, 1, 6'd7, mk_word(8'h13));
    chk("f200_w3", {TX_MFB_SRC_RDY, TX_MFB_EOF}, 2'b11);
    chk("f200_w3_pos", TX_MFB_EOF_POS, 6'd7);
    tick;
    send(1, 1, 6'd9, mk_word(8'h20));
    chk("f200_next_discarded", TX_MFB_SRC_RDY, 1'b0);
    tick;
    mi_write(32'h24, 32'd1);
    rd_chk("f200_frames", 32'h00, 32'd1);
    rd_chk("f200_octets", 32'h08, 32'd200);
    rd_chk("f200_discard", 32'h18, 32'd1);
    rd_chk("f200_padded", 32'h10, 32'd0);

    // 1500-byte frame with a 10-cycle downstream stall at word 5
    mi_write(32'h24, 32'd2);
    mi_write(32'h20, 32'd1);
    for (int k = 0; k < 24; k++) begin
      w = mk_word(8'(k * 5));
      if (k == 5) begin
        held = TX_MFB_DATA;
        TX_MFB_DST_RDY = 1'b0;
        RX_MFB_DATA = w; RX_MFB_SOF = 0; RX_MFB_EOF = 0; RX_MFB_EOF_POS = 0;
        RX_MFB_SRC_RDY = 1'b1;
        for (int c = 0; c < 10; c++) begin
          tick;
          chk("stall_rx_dst_rdy", RX_MFB_DST_RDY, 1'b0);
          chk("stall_hold", {TX_MFB_SRC_RDY, TX_MFB_DATA}, {1'b1, held});
        end
        chk("stall_held_is_w4", held, mk_word(8'd20));
        TX_MFB_DST_RDY = 1'b1;
        tick;
        RX_MFB_SRC_RDY = 1'b0;
        chk("stall_w5_data", TX_MFB_DATA, w);
      end else begin
        send(k == 0, k == 23, (k == 23) ? 6'd27 : 6'd0, w);
        chk("f1500_data", TX_MFB_DATA, w);
      end
    end
    tick;
    mi_write(32'h24, 32'd1);
    rd_chk("f1500_octets", 32'h08, 32'd1500);
    rd_chk("f1500_octets_hi", 32'h0C, 32'd0);
    rd_chk("f1500_frames", 32'h00, 32'd1);

    // Clear in the same cycle as a TX EOF transfer
    send(1, 1, 6'd63, mk_word(8'h30));
    chk("clr_race_src_rdy", TX_MFB_SRC_RDY, 1'b1);
    mi_write(32'h24, 32'd2);
    tick;
    mi_write(32'h24, 32'd1);
    rd_chk("clr_race_frames", 32'h00, 32'd0);
    rd_chk("clr_race_octets", 32'h08, 32'd0);

    // Reset mid-frame: trailing non-SOF words dropped, everything cleared
    send(1, 1, 6'd63, mk_word(8'h40));
    tick;
    mi_write(32'h24, 32'd1);
    rd_chk("prerst_frames", 32'h00, 32'd1);
    send(1, 0, 6'd0, mk_word(8'h50));
    chk("prerst_sof_fwd", TX_MFB_SRC_RDY, 1'b1);
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    chk("midrst_src_rdy", TX_MFB_SRC_RDY, 1'b0);
    send(0, 0, 6'd0, mk_word(8'h51));
    chk("midrst_w1_dropped", TX_MFB_SRC_RDY, 1'b0);
    send(0, 1, 6'd5, mk_word(8'h52));
    chk("midrst_w2_dropped", TX_MFB_SRC_RDY, 1'b0);
    tick;
    rd_chk("midrst_ctrl", 32'h20, 32'd0);
    rd_chk("midrst_snap_frames", 32'h00, 32'd0);
    mi_write(32'h24, 32'd1);
    rd_chk("midrst_frames", 32'h00, 32'd0);
    rd_chk("midrst_octets", 32'h08, 32'd0);
    rd_chk("midrst_discard", 32'h18, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
